// File: rtl/spm_mesh_pkg.sv
// Shared definitions for the SPM-to-mesh distributor: routing modes,
// tag-source selector constants and the raw-mode decoder.
package spm_mesh_pkg;

  // Routing modes held in the active-mode register.
  typedef enum logic [1:0] {
    MODE_FIXED       = 2'd0,
    MODE_ROUND_ROBIN = 2'd1,
    MODE_BROADCAST   = 2'd2
  } spm_mode_e;

  // pid_sel values: tag comes from the pkt_id port or from the top of wdata.
  localparam logic PID_FROM_PORT  = 1'b0;
  localparam logic PID_FROM_WDATA = 1'b1;

  // Map the raw 2-bit mode input onto a supported mode. The reserved
  // encoding, and broadcast when it is not built in, fall back to FIXED.
  function automatic spm_mode_e decode_mode(input logic [1:0] raw, input logic bcast_en);
    spm_mode_e m;
    case (raw)
      2'd1:    m = MODE_ROUND_ROBIN;
      2'd2:    m = bcast_en ? MODE_BROADCAST : MODE_FIXED;
      default: m = MODE_FIXED;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spm_to_mesh_dist_fifo.sv
// Plain circular buffer used as the distributor's flit storage. It keeps
// only pointers and data; the caller guarantees it never writes when full
// and never reads when empty, and owns all occupancy accounting.
module fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Pointer increment with explicit wrap so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers; reset clears the contents as well as the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/spm_to_mesh_dist.sv
// SPM-to-mesh distributor: packs scratchpad words into tagged flits,
// buffers them and presents the head flit to one or more ingress PEs
// according to the active routing mode (fixed, round-robin, broadcast).
// Broadcast support is compiled in only when SPM_MESH_BCAST_EN is defined.
module spm_to_mesh_dist
  import spm_mesh_pkg::*;
#(
  parameter int SRAM_WRD_SIZE  = 32,
  parameter int PKT_ID_WIDTH   = 4,
  parameter int FIFO_WIDTH     = SRAM_WRD_SIZE + PKT_ID_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int NUM_INGRESS_PE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic [$clog2(NUM_INGRESS_PE)-1:0] pe_sel,
  input  logic                              pid_sel,
  input  logic [PKT_ID_WIDTH-1:0]           pkt_id,
  input  logic                              enqueue,
  input  logic [SRAM_WRD_SIZE-1:0]          wdata,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
  output logic                              overflow_err,
  input  logic                              ingress_dequeue    [NUM_INGRESS_PE],
  output logic [FIFO_WIDTH-1:0]             ingress_fifo_rdata [NUM_INGRESS_PE],
  output logic                              ingress_fifo_empty [NUM_INGRESS_PE]
);

  localparam int PE_W  = $clog2(NUM_INGRESS_PE);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int LOW_W = SRAM_WRD_SIZE - PKT_ID_WIDTH;
`ifdef SPM_MESH_BCAST_EN
  localparam logic BCAST_EN = 1'b1;
`else
  localparam logic BCAST_EN = 1'b0;
`endif

  // Registered state
  spm_mode_e           mode_q, mode_d;
  logic [PE_W-1:0]     pe_sel_q, pe_sel_d;
  logic [PE_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                ovf_q, ovf_d;
`ifdef SPM_MESH_BCAST_EN
  logic [NUM_INGRESS_PE-1:0] served_q, served_d;
`endif

  // Combinational helpers
  logic [FIFO_WIDTH-1:0]     flit_s;
  logic [FIFO_WIDTH-1:0]     head_s;
  logic [NUM_INGRESS_PE-1:0] deq_s;
  logic [NUM_INGRESS_PE-1:0] target_s;
  logic [NUM_INGRESS_PE-1:0] port_vld_s;
  logic                      buf_empty_s;
  logic                      full_s;
  logic                      accept_s;
  logic                      pop_s;

  assign buf_empty_s = (occ_q == OCC_W'(0));
  assign full_s      = (occ_q == OCC_W'(FIFO_DEPTH));
  assign accept_s    = enqueue & ~full_s;

  // Build the flit: explicit tag, or tag from the top of wdata with the
  // vacated field filled by sign-extending the remaining payload.
  always_comb begin
    flit_s = '0;
    if (pid_sel == PID_FROM_WDATA) begin
      flit_s = {wdata[SRAM_WRD_SIZE-1 -: PKT_ID_WIDTH],
                {PKT_ID_WIDTH{wdata[LOW_W-1]}},
                wdata[LOW_W-1:0]};
    end else begin
      flit_s = {pkt_id, wdata};
    end
  end

  // Pack the per-PE dequeue strobes into a vector.
  always_comb begin
    deq_s = '0;
    for (int i = 0; i < NUM_INGRESS_PE; i++) begin
      deq_s[i] = ingress_dequeue[i];
    end
  end

  // Decide which ports currently see the head flit.
  always_comb begin
    target_s = '0;
    for (int i = 0; i < NUM_INGRESS_PE; i++) begin
      case (mode_q)
        MODE_ROUND_ROBIN: target_s[i] = (rr_ptr_q == PE_W'(i));
`ifdef SPM_MESH_BCAST_EN
        MODE_BROADCAST:   target_s[i] = ~served_q[i];
`endif
        default:          target_s[i] = (pe_sel_q == PE_W'(i));
      endcase
    end
  end

  // Pop decision; in broadcast the head leaves once every PE has taken it.
  always_comb begin
    pop_s = 1'b0;
`ifdef SPM_MESH_BCAST_EN
    served_d = served_q;
`endif
    if (buf_empty_s) begin
      pop_s = 1'b0;
    end else begin
      case (mode_q)
`ifdef SPM_MESH_BCAST_EN
        MODE_BROADCAST: begin
          if (&(served_q | deq_s)) begin
            pop_s    = 1'b1;
            served_d = '0;
          end else begin
            served_d = served_q | deq_s;
          end
        end
`endif
        default: pop_s = |(deq_s & target_s);
      endcase
    end
  end

  // Accounting, sticky overflow, round-robin pointer and config latching.
  always_comb begin
    occ_d    = occ_q;
    ovf_d    = ovf_q | (enqueue & full_s);
    rr_ptr_d = rr_ptr_q;
    mode_d   = mode_q;
    pe_sel_d = pe_sel_q;
    case ({accept_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (pop_s && (mode_q == MODE_ROUND_ROBIN)) begin
      if (rr_ptr_q == PE_W'(NUM_INGRESS_PE - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = rr_ptr_q + PE_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    // Routing may only change while nothing is in flight.
    if (buf_empty_s) begin
      mode_d   = decode_mode(mode, BCAST_EN);
      pe_sel_d = pe_sel;
    end else begin
      mode_d   = mode_q;
      pe_sel_d = pe_sel_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_FIXED;
      pe_sel_q <= '0;
      rr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef SPM_MESH_BCAST_EN
      served_q <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      pe_sel_q <= pe_sel_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
`ifdef SPM_MESH_BCAST_EN
      served_q <= served_d;
`endif
    end
  end

  fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_s),
    .wr_data (flit_s),
    .rd_en   (pop_s),
    .rd_data (head_s)
  );

  // Per-port view: only valid targets see the head, all others read idle.
  always_comb begin
    port_vld_s = '0;
    for (int i = 0; i < NUM_INGRESS_PE; i++) begin
      port_vld_s[i]         = ~buf_empty_s & target_s[i];
      ingress_fifo_empty[i] = ~port_vld_s[i];
      if (port_vld_s[i]) begin
        ingress_fifo_rdata[i] = head_s;
      end else begin
        ingress_fifo_rdata[i] = '0;
      end
    end
  end

  assign full         = full_s;
  assign occupancy    = occ_q;
  assign overflow_err = ovf_q;

endmodule

// File: doc/spm_to_mesh_dist.md
SPM_TO_MESH_DIST -- requirements
Module: spm_to_mesh_dist

Interface
REQ-001 SHALL have parameter SRAM_WRD_SIZE, default 32, scratchpad word width.
REQ-002 SHALL have parameter PKT_ID_WIDTH, default 4, packet-ID tag width.
REQ-003 SHALL have parameter FIFO_WIDTH, default SRAM_WRD_SIZE+PKT_ID_WIDTH, mesh flit width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, buffer entries (>=2).
REQ-005 SHALL have parameter NUM_INGRESS_PE, default 4, ingress PE count (>=2).
REQ-006 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  0=FIXED, 1=ROUND_ROBIN, 2=BROADCAST, 3=reserved (acts as FIXED).
- pe_sel  in  $clog2(NUM_INGRESS_PE)  target PE in FIXED mode.
- pid_sel  in  1  1 = derive tag from wdata; 0 = use pkt_id.
- pkt_id  in  PKT_ID_WIDTH  explicit tag.
- enqueue  in  1  write strobe from SPM.
- wdata  in  SRAM_WRD_SIZE  SPM word.
- full  out  1  buffer full.
- occupancy  out  $clog2(FIFO_DEPTH+1)  valid entries.
- overflow_err  out  1  sticky: enqueue while full.
- ingress_dequeue  in  1 x NUM_INGRESS_PE (unpacked)  per-PE pop.
- ingress_fifo_rdata  out  FIFO_WIDTH x NUM_INGRESS_PE (unpacked)  per-PE head flit.
- ingress_fifo_empty  out  1 x NUM_INGRESS_PE (unpacked)  per-PE empty.

Function
REQ-007 SHALL form flit = {pkt_id, wdata} when pid_sel=0.
REQ-008 SHALL form flit = {wdata[top PKT_ID_WIDTH bits], PKT_ID_WIDTH copies of wdata[SRAM_WRD_SIZE-PKT_ID_WIDTH-1], wdata[SRAM_WRD_SIZE-PKT_ID_WIDTH-1:0]} when pid_sel=1.
REQ-009 SHALL accept enqueue only when full=0; enqueue while full drops the word and sets overflow_err, even if a pop occurs in the same cycle.
REQ-010 SHALL present an enqueued flit on the target port one cycle after the enqueue (empty deasserts at t+1).
REQ-011 SHALL latch mode and pe_sel into active registers only in cycles where occupancy=0; in-flight flits keep their original routing.
REQ-012 SHALL, on non-target ports, drive rdata '0 and empty 1.
REQ-013 SHALL ignore dequeue from non-target ports and from any port while the buffer is empty.
REQ-014 SHALL, in FIXED mode, target active pe_sel only; a dequeue on that port pops the head.
REQ-015 SHALL, in ROUND_ROBIN mode, target rr_ptr; each pop advances rr_ptr by 1, wrapping NUM_INGRESS_PE-1 -> 0; rr_ptr resets to 0 and is not cleared on mode change.
REQ-016 SHALL, in BROADCAST mode, present the head to all PEs; keep a served mask; a PE's dequeue sets its bit and forces its empty to 1; pop the head in the cycle when (served | dequeue) is all ones, and clear the mask in that same cycle.
REQ-017 SHALL update occupancy by +1 on accepted enqueue, -1 on pop, unchanged on both; full = (occupancy==FIFO_DEPTH).

Reset
REQ-018 SHALL, on rst, clear buffer, occupancy=0, full=0, overflow_err=0, rr_ptr=0, served mask=0, active mode=FIXED, active pe_sel=0; all empty=1, all rdata='0.
REQ-019 SHALL discard all in-flight flits on rst asserted mid-transfer; no pop is reported.

Configuration
REQ-020 SHALL compile BROADCAST support only under macro SPM_MESH_BCAST_EN; without it no served mask exists and mode=2 acts as FIXED.

Structure
REQ-021 SHALL place mode enumeration (FIXED, ROUND_ROBIN, BROADCAST) and flit-format helper constants in shared package spm_mesh_pkg.
REQ-022 SHALL instantiate the existing fifo module (depth FIFO_DEPTH, width FIFO_WIDTH) as the sole storage sub-module; routing and accounting live in this module.

Verification
REQ-023 FIXED, pe_sel=2, pid_sel=0, pkt_id=0xA, wdata=0x12345678 -> cycle+1 port2 rdata=0xA12345678, empty=0; ports 0,1,3 empty=1, rdata=0.
REQ-024 pid_sel=1, wdata=0xF8000001 -> flit=0xFF8000001; wdata=0x30000005 -> flit=0x300000005.
REQ-025 ROUND_ROBIN, 5 words, each popped by current target -> served order PE0,1,2,3,0; dequeue on PE2 while PE1 targeted has no effect.
REQ-026 4 enqueues then 5th while full -> full=1, occupancy=4, overflow_err=1 and sticky; 5th word never appears.
REQ-027 BROADCAST (SPM_MESH_BCAST_EN), 1 word; PE0,PE1 dequeue cycle t, PE2,PE3 cycle t+2 -> PE0/1 empty=1 from t+1; pop at t+2; occupancy 0 at t+3.
REQ-028 rst pulsed with occupancy=3 in ROUND_ROBIN, rr_ptr=2 -> next cycle occupancy=0, all empty=1, rr_ptr=0, mode FIXED.
